// File: rtl/signed_mult_pkg.sv
// Shared definitions for the sequential sign-magnitude multiplier.
//   state_t         controller states IDLE / ITER / FIX / DONE
//   prod_width(w)   product width, 2*w-1
//   mag_width(w)    magnitude width, w-1
//   DEFAULT_WIDTH   default operand width (8)
package signed_mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int prod_width(input int w);
    return 2 * w - 1;
  endfunction

  function automatic int mag_width(input int w);
    return w - 1;
  endfunction

endpackage

// File: rtl/signed_mult_seq_ctrl_mult_step.sv
// mult_step: one combinational shift-add step of the magnitude multiplier.
// Ports:
//   acc        in   accumulated partial product (2*WIDTH-2 bits)
//   mag_a      in   multiplicand magnitude (WIDTH-1 bits)
//   mag_b      in   remaining multiplier magnitude (WIDTH-1 bits)
//   cnt        in   iteration index, shift amount for mag_a
//   acc_next   out  acc + (mag_a << cnt) when mag_b[0], else acc
//   mag_b_next out  mag_b >> 1
module mult_step
  import signed_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH-3:0]        acc,
  input  logic [WIDTH-2:0]          mag_a,
  input  logic [WIDTH-2:0]          mag_b,
  input  logic [$clog2(WIDTH)-1:0]  cnt,
  output logic [2*WIDTH-3:0]        acc_next,
  output logic [WIDTH-2:0]          mag_b_next
);

  localparam int MW = mag_width(WIDTH);
  localparam int AW = prod_width(WIDTH) - 1;

  logic [AW-1:0] addend;

  // The largest magnitude product fits in AW bits, so this add never overflows.
  assign addend     = {{(AW-MW){1'b0}}, mag_a} << cnt;
  assign acc_next   = mag_b[0] ? (acc + addend) : acc;
  assign mag_b_next = mag_b >> 1;

endmodule

// File: rtl/signed_mult_seq_ctrl.sv
// signed_mult_seq_ctrl: sequential sign-magnitude multiplier with controller.
// Accepts two WIDTH-bit two's-complement operands on start (in IDLE), runs
// one shift-add step per cycle on magnitudes, then applies the sign and
// loads the (2*WIDTH-1)-bit product register.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset
//   start    in   request, sampled only in IDLE
//   a, b     in   signed operands (WIDTH bits)
//   busy     out  high in every state except IDLE
//   done     out  one-cycle pulse, product/err valid
//   err      out  an operand was the most-negative value (magnitude unrepresentable)
//   product  out  signed result, held until the next FIX
// Build option: define EARLY_TERM_EN to leave ITER as soon as the remaining
// multiplier magnitude is zero (variable latency). Undefined: fixed latency.
module signed_mult_seq_ctrl
  import signed_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2*WIDTH-2:0]    product
);

  localparam int PW = prod_width(WIDTH);
  localparam int MW = mag_width(WIDTH);
  localparam int AW = PW - 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {MW{1'b0}}};
  localparam logic [CW-1:0]    LAST_CNT = CW'(MW - 1);

  state_t          state_reg, state_next;
  logic [AW-1:0]   acc_reg, acc_next;
  logic [MW-1:0]   mag_a_reg, mag_a_next;
  logic [MW-1:0]   mag_b_reg, mag_b_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            sign_reg, sign_next;
  logic            err_pend_reg, err_pend_next;
  logic            err_reg, err_next;
  logic [PW-1:0]   product_reg, product_next;

  logic [AW-1:0]   step_acc;
  logic [MW-1:0]   step_mag_b;
  logic [MW-1:0]   abs_a, abs_b;
  logic            early_exit;

  // For the most-negative operand the truncated magnitude is meaningless;
  // err forces the product to zero, so its value does not matter.
  assign abs_a = a[WIDTH-1] ? MW'(-a) : a[MW-1:0];
  assign abs_b = b[WIDTH-1] ? MW'(-b) : b[MW-1:0];

`ifdef EARLY_TERM_EN
  assign early_exit = (mag_b_reg == '0);
`else
  assign early_exit = 1'b0;
`endif

  mult_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc_reg),
    .mag_a      (mag_a_reg),
    .mag_b      (mag_b_reg),
    .cnt        (cnt_reg),
    .acc_next   (step_acc),
    .mag_b_next (step_mag_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      mag_a_reg    <= '0;
      mag_b_reg    <= '0;
      cnt_reg      <= '0;
      sign_reg     <= 1'b0;
      err_pend_reg <= 1'b0;
      err_reg      <= 1'b0;
      product_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      mag_a_reg    <= mag_a_next;
      mag_b_reg    <= mag_b_next;
      cnt_reg      <= cnt_next;
      sign_reg     <= sign_next;
      err_pend_reg <= err_pend_next;
      err_reg      <= err_next;
      product_reg  <= product_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    mag_a_next    = mag_a_reg;
    mag_b_next    = mag_b_reg;
    cnt_next      = cnt_reg;
    sign_next     = sign_reg;
    err_pend_next = err_pend_reg;
    err_next      = err_reg;
    product_next  = product_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          mag_a_next    = abs_a;
          mag_b_next    = abs_b;
          // A zero operand must give +0, never a negated zero.
          sign_next     = (a[WIDTH-1] ^ b[WIDTH-1]) & (a != '0) & (b != '0);
          acc_next      = '0;
          cnt_next      = '0;
          err_pend_next = (a == MOST_NEG) || (b == MOST_NEG);
          state_next    = ITER;
        end
      end
      ITER: begin
        if (early_exit) begin
          state_next = FIX;
        end else begin
          acc_next   = step_acc;
          mag_b_next = step_mag_b;
          cnt_next   = cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) begin
            state_next = FIX;
          end
        end
      end
      FIX: begin
        if (err_pend_reg) begin
          product_next = '0;
        end else if (sign_reg) begin
          product_next = -{1'b0, acc_reg};
        end else begin
          product_next = {1'b0, acc_reg};
        end
        err_next   = err_pend_reg;
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);
  assign err     = err_reg;
  assign product = product_reg;

endmodule

// File: tb/tb_signed_mult_seq_ctrl.sv
// Self-checking bench for signed_mult_seq_ctrl (WIDTH=8).
// A transaction-level model (integer multiply, latency from the multiplier
// value) predicts busy/done/err/product every cycle; directed vectors pin
// known products and latencies. Honours EARLY_TERM_EN when defined.
module tb_signed_mult_seq_ctrl;

  localparam int W  = 8;
  localparam int PW = 2 * W - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  a, b;
  logic          busy, done, err;
  logic [PW-1:0] product;

  always #5 clk = ~clk;

  signed_mult_seq_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .product (product)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Edge number (after accept edge E0) on which the product is loaded.
  function automatic int fix_edge(input logic [W-1:0] bv);
    int bi, m, h;
    bi = $signed(bv);
    m  = (bi < 0 ? -bi : bi) & ((1 << (W - 1)) - 1);
`ifdef EARLY_TERM_EN
    if (m == 0) return 2;
    h = 0;
    for (int i = 0; i < W - 1; i++) if (m[i]) h = i;
    return (h + 3 > W) ? W : h + 3;
`else
    h = m;
    return W;
`endif
  endfunction

  function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] av, input logic [W-1:0] bv);
    int ai, bi, p;
    ai = $signed(av);
    bi = $signed(bv);
    p  = ai * bi;
    return p[PW-1:0];
  endfunction

  // Behavioural model state.
  bit            chk_en = 1'b0;
  bit            m_active = 1'b0, m_done = 1'b0, m_err = 1'b0, m_err_f = 1'b0;
  int            m_t = 0, m_lat = 0, m_a = 0, m_b = 0;
  logic [PW-1:0] m_prod = '0, m_final = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_prod   = '0;
      chk_en   = 1'b1;
    end else if (!m_active) begin
      m_done = 1'b0;
      if (start) begin
        m_active = 1'b1;
        m_t      = 0;
        m_lat    = fix_edge(b);
        m_a      = $signed(a);
        m_b      = $signed(b);
        m_err_f  = (a == 8'h80) || (b == 8'h80);
        m_final  = m_err_f ? '0 : ref_prod(a, b);
      end
    end else begin
      m_t++;
      if (m_t == m_lat) begin
        m_prod = m_final;
        m_err  = m_err_f;
        m_done = 1'b1;
      end else if (m_t == m_lat + 1) begin
        m_active = 1'b0;
        m_done   = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_active));
      check("done", 32'(done), 32'(m_done));
      check("err", 32'(err), 32'(m_err));
      check("product", 32'(product), 32'(m_prod));
      if (done && m_done)
        $display("op a=%0d b=%0d product=%h err=%0d", m_a, m_b, product, err);
    end
  end

  // Directed operation from IDLE: checks latency and literal result.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [PW-1:0] exp_p, input logic exp_e);
    int k;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: got no done, expected done within 40 cycles");
    end else begin
      check("latency", 32'(k), 32'(fix_edge(bv)));
      check("lit_product", 32'(product), 32'(exp_p));
      check("lit_err", 32'(err), 32'(exp_e));
    end
  endtask

  logic [W-1:0] corner [6];

  initial begin
    corner[0] = 8'h80; corner[1] = 8'h81; corner[2] = 8'h7F;
    corner[3] = 8'h00; corner[4] = 8'hFF; corner[5] = 8'h01;

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    reset = 1'b0;

    run_op(8'hFB, 8'h03, 15'h7FF1, 1'b0);   // -5 * 3
    run_op(8'h7F, 8'h7F, 15'h3F01, 1'b0);   // 127 * 127
    run_op(8'h81, 8'h81, 15'h3F01, 1'b0);   // -127 * -127
    run_op(8'h81, 8'h7F, 15'h40FF, 1'b0);   // -127 * 127
    run_op(8'h00, 8'hF9, 15'h0000, 1'b0);   // 0 * -7
    run_op(8'h80, 8'h05, 15'h0000, 1'b1);   // -128 * 5
    run_op(8'h09, 8'h01, 15'h0009, 1'b0);   // 9 * 1

    // Reset in the middle of ITER.
    @(negedge clk);
    a = 8'd50; b = 8'hFD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    repeat (12) @(negedge clk);

    // start held high with operands changing every cycle.
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Random traffic with corner operands and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 5)] : W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 5)] : W'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
